// File: rtl/seg_pkg.sv
// Shared constants, scan state type and segment helpers for the seven-segment scan driver.
package seg_pkg;

   // Common-anode patterns, active-low, {dp, g, f, e, d, c, b, a}.
   localparam logic [7:0] SEG_0     = 8'hC0;
   localparam logic [7:0] SEG_1     = 8'hF9;
   localparam logic [7:0] SEG_2     = 8'hA4;
   localparam logic [7:0] SEG_3     = 8'hB0;
   localparam logic [7:0] SEG_4     = 8'h99;
   localparam logic [7:0] SEG_5     = 8'h92;
   localparam logic [7:0] SEG_6     = 8'h82;
   localparam logic [7:0] SEG_7     = 8'hF8;
   localparam logic [7:0] SEG_8     = 8'h80;
   localparam logic [7:0] SEG_9     = 8'h90;
   localparam logic [7:0] SEG_BLANK = 8'hFF;
   localparam logic [5:0] DIGIT_OFF = 6'b111111;

   typedef enum logic {SHOW = 1'b0, BLANK = 1'b1} scan_state_t;

   function automatic logic [7:0] digit_to_seg(input logic [3:0] d);
      logic [7:0] seg;
      case (d)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
      return seg;
   endfunction

   // Active-low one-hot digit enable; indices above 5 select nothing.
   function automatic logic [5:0] digit_sel(input logic [2:0] idx);
      return ~(6'b000001 << idx);
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 6-bit binary to two-digit BCD converter by repeated subtract-10.
// Fixed latency: done is high in the 7th cycle after start, whatever the value.
module bin2bcd_seq (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [5:0] value,
   output logic       done,
   output logic [3:0] tens,
   output logic [3:0] ones
);
   localparam logic [2:0] LAST_STEP = 3'd6;

   logic       r_active;
   logic [2:0] r_step;
   logic [5:0] r_rem;
   logic [3:0] r_tens;

   // Six subtract slots cover 63 -> 3; start wins over finishing so a restart has no gap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_active <= 1'b0;
         r_step   <= 3'd0;
         r_rem    <= 6'd0;
         r_tens   <= 4'd0;
      end else if (start) begin
         r_active <= 1'b1;
         r_step   <= 3'd0;
         r_rem    <= value;
         r_tens   <= 4'd0;
      end else if (r_active) begin
         if (r_step == LAST_STEP) begin
            r_active <= 1'b0;
         end else begin
            r_step <= r_step + 3'd1;
            if (r_rem >= 6'd10) begin
               r_rem  <= r_rem - 6'd10;
               r_tens <= r_tens + 4'd1;
            end
         end
      end
   end

   assign done = r_active && (r_step == LAST_STEP);
   assign tens = r_tens;
   assign ones = r_rem[3:0];

endmodule

// File: rtl/seg_scan_driver.sv
// Six-digit multiplexed seven-segment driver with sequential BCD conversion and blanking gaps.
// Optional colon blink on idx 4 and idx 2 when SEG_SCAN_DP_BLINK_EN is defined.
module seg_scan_driver
   import seg_pkg::*;
#(
   parameter int unsigned SCAN_DIV     = 8192,
   parameter int unsigned BLANK_CYCLES = 64
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       upd,
   input  logic [5:0] hours,
   input  logic [5:0] minutes,
   input  logic [5:0] seconds,
   output logic       busy,
   output logic [7:0] number,
   output logic [5:0] digit_block
);
   localparam int unsigned CNT_MAX = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
   localparam int unsigned CW      = $clog2(CNT_MAX + 1);
   localparam logic [CW-1:0] SHOW_LAST  = CW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] BLANK_LAST = (BLANK_CYCLES == 0) ? '0 : CW'(BLANK_CYCLES - 1);

   logic             r_busy, r_pend;
   logic [5:0]       r_pend_h, r_pend_m, r_pend_s;
   logic [5:0][3:0]  r_shadow;
   scan_state_t      r_state;
   logic [CW-1:0]    r_cnt;
   logic [2:0]       r_idx;
   logic [7:0]       r_number;
   logic [5:0]       r_digit;

   logic             w_done_h, w_done_m, w_done_s, w_done, w_use_pend, w_start;
   logic [5:0]       w_val_h, w_val_m, w_val_s;
   logic [3:0]       w_tens_h, w_ones_h, w_tens_m, w_ones_m, w_tens_s, w_ones_s;
   logic [2:0]       w_idx_next;
   logic [7:0]       w_seg_cur, w_seg_next;
   logic             w_dp_cur, w_dp_next;

   assign w_done     = w_done_h & w_done_m & w_done_s;
   assign w_use_pend = w_done & r_pend;
   // An upd on the commit cycle restarts straight away, exactly as a queued one would.
   assign w_start    = (upd & ~r_busy) | (w_done & (r_pend | upd));
   assign w_val_h    = w_use_pend ? r_pend_h : hours;
   assign w_val_m    = w_use_pend ? r_pend_m : minutes;
   assign w_val_s    = w_use_pend ? r_pend_s : seconds;

   bin2bcd_seq u_conv_h (.clk(clk), .rst(rst), .start(w_start), .value(w_val_h),
                         .done(w_done_h), .tens(w_tens_h), .ones(w_ones_h));
   bin2bcd_seq u_conv_m (.clk(clk), .rst(rst), .start(w_start), .value(w_val_m),
                         .done(w_done_m), .tens(w_tens_m), .ones(w_ones_m));
   bin2bcd_seq u_conv_s (.clk(clk), .rst(rst), .start(w_start), .value(w_val_s),
                         .done(w_done_s), .tens(w_tens_s), .ones(w_ones_s));

`ifdef SEG_SCAN_DP_BLINK_EN
   logic r_dp_tog;
   assign w_dp_cur  = ~(r_dp_tog & ((r_idx == 3'd4) | (r_idx == 3'd2)));
   assign w_dp_next = ~(r_dp_tog & ((w_idx_next == 3'd4) | (w_idx_next == 3'd2)));

   // Colon toggle flips once per committed time value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_dp_tog <= 1'b0;
      end else if (w_done) begin
         r_dp_tog <= ~r_dp_tog;
      end
   end
`else
   assign w_dp_cur  = 1'b1;
   assign w_dp_next = 1'b1;
`endif

   // Busy/pending bookkeeping and atomic commit of all six digits.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_busy   <= 1'b0;
         r_pend   <= 1'b0;
         r_pend_h <= 6'd0;
         r_pend_m <= 6'd0;
         r_pend_s <= 6'd0;
         r_shadow <= '0;
      end else begin
         if (w_start) begin
            r_busy <= 1'b1;
         end else if (w_done) begin
            r_busy <= 1'b0;
         end
         if (upd && r_busy && !(w_done && !r_pend)) begin
            r_pend   <= 1'b1;
            r_pend_h <= hours;
            r_pend_m <= minutes;
            r_pend_s <= seconds;
         end else if (w_done) begin
            r_pend <= 1'b0;
         end
         if (w_done) begin
            r_shadow <= {w_tens_h, w_ones_h, w_tens_m, w_ones_m, w_tens_s, w_ones_s};
         end
      end
   end

   assign w_idx_next = (r_idx == 3'd5) ? 3'd0 : r_idx + 3'd1;

   // Shadow digit lookups for the digit being entered.
   always_comb begin
      w_seg_cur  = digit_to_seg(r_shadow[r_idx]);
      w_seg_next = digit_to_seg(r_shadow[w_idx_next]);
   end

   // Scan FSM: outputs are loaded only on state entry, so a commit never disturbs a lit digit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= BLANK;
         r_cnt    <= '0;
         r_idx    <= 3'd0;
         r_number <= SEG_BLANK;
         r_digit  <= DIGIT_OFF;
      end else begin
         case (r_state)
            SHOW: begin
               if (r_cnt == SHOW_LAST) begin
                  r_cnt <= '0;
                  r_idx <= w_idx_next;
                  if (BLANK_CYCLES == 0) begin
                     r_number <= {w_dp_next, w_seg_next[6:0]};
                     r_digit  <= digit_sel(w_idx_next);
                  end else begin
                     r_state  <= BLANK;
                     r_number <= SEG_BLANK;
                     r_digit  <= DIGIT_OFF;
                  end
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            BLANK: begin
               if ((BLANK_CYCLES == 0) || (r_cnt == BLANK_LAST)) begin
                  r_state  <= SHOW;
                  r_cnt    <= '0;
                  r_number <= {w_dp_cur, w_seg_cur[6:0]};
                  r_digit  <= digit_sel(r_idx);
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            default: begin
               r_state  <= BLANK;
               r_cnt    <= '0;
               r_number <= SEG_BLANK;
               r_digit  <= DIGIT_OFF;
            end
         endcase
      end
   end

   assign busy        = r_busy;
   assign number      = r_number;
   assign digit_block = r_digit;

endmodule
